// File: rtl/axil_reg_bridge_pkg.sv
// Shared constants and enums for the AXI4-Lite to req/ack register bridge.
package axil_reg_bridge_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} be_state_e;
  typedef enum logic {GNT_WR, GNT_RD} gnt_e;

endpackage

// File: rtl/axil_reg_bridge_tmo.sv
// Backend ack timeout: o_expire marks the last cycle of a TIMEOUT_CYCLES-long access.
module axil_reg_bridge_tmo #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  assign o_expire = i_start && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_cnt <= '0;
    else if (!i_start || i_ack) r_cnt <= '0;
    else if (!o_expire)        r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave bridging to a single-outstanding req/ack CSR bus.
// Optional backend timeout enabled by defining AXIL_REG_BRIDGE_TIMEOUT_EN.
module axil_reg_bridge
  import axil_reg_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_SPAN      = 4096,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [2:0]              s_awprot,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  output logic [1:0]              s_bresp,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [2:0]              s_arprot,
  output logic                    s_rvalid,
  input  logic                    s_rready,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    reg_req,
  output logic                    reg_wr,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  output logic [DATA_WIDTH/8-1:0] reg_wstrb,
  input  logic                    reg_ack,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);

  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(SW - 1);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return 64'(a) < 64'(ADDR_SPAN);
  endfunction

  logic                  r_init;
  logic                  r_aw_full, r_w_full, r_ar_full;
  logic [ADDR_WIDTH-1:0] r_aw_addr, r_ar_addr;
  logic [DATA_WIDTH-1:0] r_w_data;
  logic [SW-1:0]         r_w_strb;
  be_state_e             r_state, w_state_nxt;
  gnt_e                  r_gnt, w_gnt_nxt, r_prio, w_prio_nxt, w_pick;
  logic                  r_reg_req, w_req_nxt, r_reg_wr, w_wr_nxt;
  logic [ADDR_WIDTH-1:0] r_reg_addr, w_addr_nxt, w_sel_addr;
  logic [DATA_WIDTH-1:0] r_reg_wdata, w_wdata_nxt, r_rdata, w_rdata_nxt;
  logic [SW-1:0]         r_reg_wstrb, w_wstrb_nxt;
  logic [1:0]            r_resp, w_resp_nxt;
  logic                  w_tmo;

  logic w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
  logic w_aw_full_nxt, w_w_full_nxt, w_ar_full_nxt, w_wr_pend, w_rd_pend;
  logic [ADDR_WIDTH-1:0] w_aw_addr_nxt, w_ar_addr_nxt;
  logic [DATA_WIDTH-1:0] w_w_data_nxt;
  logic [SW-1:0]         w_w_strb_nxt;
  logic                  w_unused_cfg;

  assign w_unused_cfg = ^{s_awprot, s_arprot, 1'(TIMEOUT_CYCLES)};

  assign s_awready = r_init & ~r_aw_full;
  assign s_wready  = r_init & ~r_w_full;
  assign s_arready = r_init & ~r_ar_full;
  assign s_bvalid  = (r_state == ST_RESP) && (r_gnt == GNT_WR);
  assign s_rvalid  = (r_state == ST_RESP) && (r_gnt == GNT_RD);
  assign s_bresp   = r_resp;
  assign s_rresp   = r_resp;
  assign s_rdata   = r_rdata;
  assign reg_req   = r_reg_req;
  assign reg_wr    = r_reg_wr;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign reg_wstrb = r_reg_wstrb;

  assign w_aw_hs = s_awvalid & s_awready;
  assign w_w_hs  = s_wvalid  & s_wready;
  assign w_ar_hs = s_arvalid & s_arready;
  assign w_b_hs  = s_bvalid  & s_bready;
  assign w_r_hs  = s_rvalid  & s_rready;

  // Arbitrate on next-cycle holder contents so a fresh accept reaches reg_req one cycle later.
  assign w_aw_full_nxt = w_aw_hs | (r_aw_full & ~w_b_hs);
  assign w_w_full_nxt  = w_w_hs  | (r_w_full  & ~w_b_hs);
  assign w_ar_full_nxt = w_ar_hs | (r_ar_full & ~w_r_hs);
  assign w_aw_addr_nxt = w_aw_hs ? s_awaddr : r_aw_addr;
  assign w_ar_addr_nxt = w_ar_hs ? s_araddr : r_ar_addr;
  assign w_w_data_nxt  = w_w_hs  ? s_wdata  : r_w_data;
  assign w_w_strb_nxt  = w_w_hs  ? s_wstrb  : r_w_strb;
  assign w_wr_pend     = w_aw_full_nxt & w_w_full_nxt;
  assign w_rd_pend     = w_ar_full_nxt;

`ifdef AXIL_REG_BRIDGE_TIMEOUT_EN
  axil_reg_bridge_tmo #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (r_state == ST_ACCESS),
    .i_ack    (reg_ack),
    .o_expire (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_prio_nxt  = r_prio;
    w_req_nxt   = r_reg_req;
    w_wr_nxt    = r_reg_wr;
    w_addr_nxt  = r_reg_addr;
    w_wdata_nxt = r_reg_wdata;
    w_wstrb_nxt = r_reg_wstrb;
    w_resp_nxt  = r_resp;
    w_rdata_nxt = r_rdata;
    w_pick      = GNT_WR;
    w_sel_addr  = '0;
    case (r_state)
      ST_IDLE: if (w_wr_pend || w_rd_pend) begin
        if (w_wr_pend && w_rd_pend) begin
          w_pick     = r_prio;
          w_prio_nxt = (r_prio == GNT_WR) ? GNT_RD : GNT_WR;
        end else begin
          w_pick = w_wr_pend ? GNT_WR : GNT_RD;
        end
        w_gnt_nxt  = w_pick;
        w_sel_addr = (w_pick == GNT_WR) ? w_aw_addr_nxt : w_ar_addr_nxt;
        if (in_range(w_sel_addr)) begin
          w_state_nxt = ST_ACCESS;
          w_req_nxt   = 1'b1;
          w_wr_nxt    = (w_pick == GNT_WR);
          w_addr_nxt  = w_sel_addr & ALIGN_MASK;
          w_wdata_nxt = (w_pick == GNT_WR) ? w_w_data_nxt : '0;
          w_wstrb_nxt = (w_pick == GNT_WR) ? w_w_strb_nxt : '0;
        end else begin
          w_state_nxt = ST_RESP;
          w_resp_nxt  = RESP_SLVERR;
          w_rdata_nxt = '0;
        end
      end
      ST_ACCESS: if (reg_ack) begin
        w_state_nxt = ST_RESP;
        w_req_nxt   = 1'b0;
        w_resp_nxt  = reg_err ? RESP_SLVERR : RESP_OKAY;
        w_rdata_nxt = r_reg_wr ? '0 : reg_rdata;
      end else if (w_tmo) begin
        w_state_nxt = ST_RESP;
        w_req_nxt   = 1'b0;
        w_resp_nxt  = RESP_SLVERR;
        w_rdata_nxt = '0;
      end
      ST_RESP: if (w_b_hs || w_r_hs) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init      <= 1'b0;
      r_aw_full   <= 1'b0;
      r_w_full    <= 1'b0;
      r_ar_full   <= 1'b0;
      r_aw_addr   <= '0;
      r_ar_addr   <= '0;
      r_w_data    <= '0;
      r_w_strb    <= '0;
      r_state     <= ST_IDLE;
      r_gnt       <= GNT_WR;
      r_prio      <= GNT_WR;
      r_reg_req   <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_wstrb <= '0;
      r_resp      <= RESP_OKAY;
      r_rdata     <= '0;
    end else begin
      r_init      <= 1'b1;
      r_aw_full   <= w_aw_full_nxt;
      r_w_full    <= w_w_full_nxt;
      r_ar_full   <= w_ar_full_nxt;
      r_aw_addr   <= w_aw_addr_nxt;
      r_ar_addr   <= w_ar_addr_nxt;
      r_w_data    <= w_w_data_nxt;
      r_w_strb    <= w_w_strb_nxt;
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_prio      <= w_prio_nxt;
      r_reg_req   <= w_req_nxt;
      r_reg_wr    <= w_wr_nxt;
      r_reg_addr  <= w_addr_nxt;
      r_reg_wdata <= w_wdata_nxt;
      r_reg_wstrb <= w_wstrb_nxt;
      r_resp      <= w_resp_nxt;
      r_rdata     <= w_rdata_nxt;
    end
  end

endmodule
